// File: rtl/sync_event_coalescer_pkg.sv
// Shared types and constants for the source-side event coalescer.
// Holds the FSM state encoding and the width rule for the saturating adder.
package sync_event_coalescer_pkg;

    // 2'd3 is unused and falls back to IDLE in the next-state decode.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_e;

    // One extra bit holds the carry that detects saturation.
    function automatic int sat_sum_w(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/sync_event_coalescer_sat_accum.sv
// W-bit saturating event accumulator with a sticky overflow flag.
// On load, the count restarts from this cycle's increment so launch-cycle events are kept.
module sync_sat_accum
    import sync_event_coalescer_pkg::*;
#(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          sCLK,
    input  logic          sRST_N,
    input  logic          inc,
    input  logic [AW-1:0] inc_amt,
    input  logic          load,
    input  logic          clr_ovf,
    output logic [W-1:0]  acc,
    output logic          overflow
);

    localparam int SW = sat_sum_w(W);

    logic [SW-1:0] sum;
    logic          sat_hit;

    assign sum     = {1'b0, acc} + SW'(inc_amt);
    assign sat_hit = inc && !load && sum[W];

    always_ff @(posedge sCLK or negedge sRST_N) begin
        if (!sRST_N) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else begin
            if (load)
                acc <= inc ? W'(inc_amt) : '0;
            else if (sat_hit)
                acc <= '1;
            else if (inc)
                acc <= sum[W-1:0];
            // Setting wins over a same-cycle clear.
            overflow <= sat_hit || (overflow && !clr_ovf);
        end
    end

endmodule

// File: rtl/sync_event_coalescer.sv
// Source-side coalescer: counts events and launches a snapshot of the count
// into the toggle handshake whenever it is ready and the count is worth sending.
module sync_event_coalescer
    import sync_event_coalescer_pkg::*;
#(
    parameter int W      = 8,
    parameter int AW     = 4,
    parameter int THRESH = 1
) (
    input  logic          sCLK,
    input  logic          sRST_N,
    input  logic          sInc,
    input  logic [AW-1:0] sIncAmt,
    input  logic          sFlush,
    input  logic          sClrOvf,
    input  logic          sRDY,
    output logic          sEN,
    output logic [W-1:0]  sData,
    output logic          sPending,
    output logic          sOverflow
);

    localparam logic [W-1:0] TH = W'(THRESH);

    state_e       state, state_nxt;
    logic         launch;
    logic         trigger;
    logic [W-1:0] acc;

    sync_sat_accum #(.W(W), .AW(AW)) u_acc (
        .sCLK     (sCLK),
        .sRST_N   (sRST_N),
        .inc      (sInc),
        .inc_amt  (sIncAmt),
        .load     (launch),
        .clr_ovf  (sClrOvf),
        .acc      (acc),
        .overflow (sOverflow)
    );

    assign trigger  = (acc >= TH) || (sFlush && (acc != '0));
    assign sPending = (acc != '0);

    always_comb begin
        state_nxt = IDLE;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (trigger && sRDY) begin
                    state_nxt = SEND;
                    launch    = 1'b1;
                end
            end
            SEND:    state_nxt = WAIT;
            WAIT:    state_nxt = sRDY ? IDLE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    // sData is captured on entry to SEND so it is valid alongside sEN and held through WAIT.
    always_ff @(posedge sCLK or negedge sRST_N) begin
        if (!sRST_N) begin
            state <= IDLE;
            sEN   <= 1'b0;
            sData <= '0;
        end else begin
            state <= state_nxt;
            sEN   <= launch;
            if (launch)
                sData <= acc;
        end
    end

endmodule

// File: tb/tb_sync_event_coalescer.sv
// Directed bench: coalescer driving a behavioural toggle handshake into an unrelated dCLK domain.
module tb_sync_event_coalescer;
    import sync_event_coalescer_pkg::*;

    logic       sCLK, dCLK, sRST_N;
    logic       sInc, sFlush, sClrOvf;
    logic [3:0] sIncAmt;
    logic       sRDY, sEN, sPending, sOverflow;
    logic [7:0] sData;
    logic       sEN8, sPending8, sOverflow8;
    logic [7:0] sData8;
    logic       auto_mode, man_rdy;

    int checks = 0;
    int errors = 0;

    sync_event_coalescer #(.W(8), .AW(4), .THRESH(1)) dut (
        .sCLK(sCLK), .sRST_N(sRST_N), .sInc(sInc), .sIncAmt(sIncAmt), .sFlush(sFlush),
        .sClrOvf(sClrOvf), .sRDY(sRDY), .sEN(sEN), .sData(sData),
        .sPending(sPending), .sOverflow(sOverflow)
    );

    sync_event_coalescer #(.W(8), .AW(4), .THRESH(8)) dut8 (
        .sCLK(sCLK), .sRST_N(sRST_N), .sInc(sInc), .sIncAmt(sIncAmt), .sFlush(sFlush),
        .sClrOvf(sClrOvf), .sRDY(man_rdy), .sEN(sEN8), .sData(sData8),
        .sPending(sPending8), .sOverflow(sOverflow8)
    );

    initial begin sCLK = 0; forever #5 sCLK = ~sCLK; end
    initial begin dCLK = 0; forever #7 dCLK = ~dCLK; end

    // Behavioural toggle/pulse handshake sharing sRST_N.
    logic       stog, d1, d2, d3, a1, a2, hs_rdy, dPulse;
    logic [7:0] dData;
    int         dcnt;

    always @(posedge sCLK or negedge sRST_N)
        if (!sRST_N) begin stog <= 0; a1 <= 0; a2 <= 0; end
        else begin
            if (sEN) stog <= ~stog;
            a1 <= d3;
            a2 <= a1;
        end

    always @(posedge dCLK or negedge sRST_N)
        if (!sRST_N) begin d1 <= 0; d2 <= 0; d3 <= 0; dData <= 0; dcnt <= 0; end
        else begin
            d1 <= stog;
            d2 <= d1;
            d3 <= d2;
            if (dPulse) begin dData <= sData; dcnt <= dcnt + 1; end
        end

    assign dPulse = d2 ^ d3;
    assign hs_rdy = (a2 == stog);
    assign sRDY   = auto_mode ? hs_rdy : man_rdy;

    task automatic tick();
        @(posedge sCLK); #1;
    endtask

    task automatic do_reset();
        sRST_N = 0; sInc = 0; sIncAmt = 0; sFlush = 0; sClrOvf = 0;
        man_rdy = 1; auto_mode = 0;
        tick(); tick();
        sRST_N = 1;
        tick();
    endtask

    task automatic test_reset();
        sRST_N = 0; #2;
        checks++; if (sEN !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", sEN); end
        checks++; if (sData !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", sData); end
        checks++; if (sPending !== 1'b0 || sOverflow !== 1'b0) begin errors++;
            $display("FAIL reset_flags: got pend=%b ovf=%b want 0 0", sPending, sOverflow); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", dut.state); end
        do_reset();
    endtask

    task automatic test_single_event();
        int n;
        do_reset(); auto_mode = 1;
        sInc = 1; sIncAmt = 3; tick(); sInc = 0;
        checks++; if (sPending !== 1'b1 || sEN !== 1'b0) begin errors++;
            $display("FAIL single_accum: got pend=%b en=%b want 1 0", sPending, sEN); end
        tick();
        checks++; if (sEN !== 1'b1 || sData !== 8'd3 || dut.acc !== 8'd0) begin errors++;
            $display("FAIL single_launch: got en=%b data=%0d acc=%0d want 1 3 0", sEN, sData, dut.acc); end
        tick();
        checks++; if (sEN !== 1'b0 || sRDY !== 1'b0 || dut.state !== WAIT) begin errors++;
            $display("FAIL single_wait: got en=%b rdy=%b st=%0d want 0 0 2", sEN, sRDY, dut.state); end
        n = 0;
        while (sRDY !== 1'b1 && n < 50) begin tick(); n++; end
        checks++; if (n >= 50) begin errors++; $display("FAIL single_ack_timeout: got %0d cycles want <50", n); end
        checks++; if (dcnt !== 1 || dData !== 8'd3) begin errors++;
            $display("FAIL single_dest: got cnt=%0d data=%0d want 1 3", dcnt, dData); end
        tick();
        checks++; if (dut.state !== IDLE || sEN !== 1'b0) begin errors++;
            $display("FAIL single_idle: got st=%0d en=%b want 0 0", dut.state, sEN); end
    endtask

    task automatic test_burst_during_wait();
        int pulses;
        do_reset();
        sInc = 1; sIncAmt = 1; tick(); sInc = 0;
        tick(); man_rdy = 0;
        pulses = 0;
        sInc = 1; sIncAmt = 2;
        for (int i = 0; i < 5; i++) begin tick(); if (sEN) pulses++; end
        sInc = 0;
        checks++; if (pulses !== 0) begin errors++; $display("FAIL burst_no_en: got %0d pulses want 0", pulses); end
        checks++; if (dut.acc !== 8'd10 || sData !== 8'd1) begin errors++;
            $display("FAIL burst_hold: got acc=%0d data=%0d want 10 1", dut.acc, sData); end
        man_rdy = 1; tick();
        checks++; if (sEN !== 1'b0) begin errors++; $display("FAIL burst_idle_gap: got en=%b want 0", sEN); end
        tick();
        checks++; if (sEN !== 1'b1 || sData !== 8'd10) begin errors++;
            $display("FAIL burst_send: got en=%b data=%0d want 1 10", sEN, sData); end
    endtask

    task automatic test_launch_collision();
        int total;
        do_reset(); man_rdy = 0;
        sInc = 1; sIncAmt = 4; tick();
        sIncAmt = 5; man_rdy = 1; tick(); sInc = 0;
        checks++; if (sEN !== 1'b1 || sData !== 8'd4 || dut.acc !== 8'd5) begin errors++;
            $display("FAIL collide_launch: got en=%b data=%0d acc=%0d want 1 4 5", sEN, sData, dut.acc); end
        total = sData;
        man_rdy = 0; tick(); tick();
        man_rdy = 1; tick(); tick();
        checks++; if (sEN !== 1'b1 || sData !== 8'd5) begin errors++;
            $display("FAIL collide_second: got en=%b data=%0d want 1 5", sEN, sData); end
        total += sData;
        checks++; if (total !== 9) begin errors++; $display("FAIL collide_total: got %0d want 9", total); end
    endtask

    task automatic test_saturation();
        do_reset();
        sInc = 1; sIncAmt = 1; tick(); sInc = 0;
        tick(); man_rdy = 0;
        sInc = 1; sIncAmt = 15;
        for (int i = 0; i < 60; i++) tick();
        sInc = 0;
        checks++; if (dut.acc !== 8'd255 || sOverflow !== 1'b1) begin errors++;
            $display("FAIL sat_acc: got acc=%0d ovf=%b want 255 1", dut.acc, sOverflow); end
        sClrOvf = 1; tick(); sClrOvf = 0;
        checks++; if (sOverflow !== 1'b0) begin errors++; $display("FAIL sat_clr: got %b want 0", sOverflow); end
        sClrOvf = 1; sInc = 1; tick(); sClrOvf = 0; sInc = 0;
        checks++; if (sOverflow !== 1'b1) begin errors++; $display("FAIL sat_set_wins: got %b want 1", sOverflow); end
        man_rdy = 1; tick(); tick();
        checks++; if (sEN !== 1'b1 || sData !== 8'd255) begin errors++;
            $display("FAIL sat_send: got en=%b data=%0d want 1 255", sEN, sData); end
    endtask

    task automatic test_thresh_flush();
        int pulses;
        do_reset();
        sInc = 1; sIncAmt = 5; tick(); sInc = 0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (sEN8) pulses++; end
        checks++; if (pulses !== 0 || sPending8 !== 1'b1) begin errors++;
            $display("FAIL thr_below: got pulses=%0d pend=%b want 0 1", pulses, sPending8); end
        sFlush = 1; tick();
        checks++; if (sEN8 !== 1'b1 || sData8 !== 8'd5) begin errors++;
            $display("FAIL thr_flush: got en=%b data=%0d want 1 5", sEN8, sData8); end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (sEN8) pulses++; end
        sFlush = 0;
        checks++; if (pulses !== 0) begin errors++; $display("FAIL thr_flush_empty: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_reset_mid_wait();
        int n;
        do_reset(); auto_mode = 1;
        sInc = 1; sIncAmt = 1; tick(); sInc = 0;
        tick(); tick();
        sInc = 1; sIncAmt = 7; tick(); sInc = 0;
        checks++; if (dut.state !== WAIT || dut.acc !== 8'd7) begin errors++;
            $display("FAIL rmid_pre: got st=%0d acc=%0d want 2 7", dut.state, dut.acc); end
        sRST_N = 0; #1;
        checks++; if (sEN !== 1'b0 || sData !== 8'd0 || dut.acc !== 8'd0 || sOverflow !== 1'b0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL rmid_async: got en=%b data=%0d acc=%0d ovf=%b st=%0d want 0 0 0 0 0",
                     sEN, sData, dut.acc, sOverflow, dut.state);
        end
        sRST_N = 1; tick();
        sInc = 1; sIncAmt = 6; tick(); sInc = 0;
        tick();
        checks++; if (sEN !== 1'b1 || sData !== 8'd6) begin errors++;
            $display("FAIL rmid_after: got en=%b data=%0d want 1 6", sEN, sData); end
        n = 0;
        tick();
        while (sRDY !== 1'b1 && n < 50) begin tick(); n++; end
        checks++; if (n >= 50 || dData !== 8'd6 || dcnt !== 1) begin errors++;
            $display("FAIL rmid_dest: got n=%0d data=%0d cnt=%0d want <50 6 1", n, dData, dcnt); end
    endtask

    initial begin
        sRST_N = 0; sInc = 0; sIncAmt = 0; sFlush = 0; sClrOvf = 0;
        man_rdy = 1; auto_mode = 0;
        test_reset();
        test_single_event();
        test_burst_during_wait();
        test_launch_collision();
        test_saturation();
        test_thresh_flush();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_event_coalescer.md
Name: sync_event_coalescer

Overview:
- Source-side stage in front of the toggle/pulse handshake synchronizer.
- Accumulates event increments arriving on sCLK into a counter.
- When the handshake is ready, snapshots the count into a held data register and issues a one-cycle send enable.
- The destination samples the held count on its received pulse, so bursts of source events cross domains as counts and none are lost.

Parameters:
- W, 8: width of accumulator and snapshot register.
- AW, 4: width of per-cycle increment amount.
- THRESH, 1: minimum accumulated count that triggers an automatic send (1..2^W-1).

Ports:
- sCLK  in  1  source clock.
- sRST_N  in  1  reset, asynchronous, active-low.
- sInc  in  1  increment strobe, qualifies sIncAmt.
- sIncAmt  in  AW  increment amount; 0 is legal and changes nothing.
- sFlush  in  1  force a send of any nonzero count regardless of THRESH.
- sClrOvf  in  1  clear sticky overflow.
- sRDY  in  1  ready from handshake stage (high = previous transfer acknowledged).
- sEN  out  1  send enable to handshake stage, registered, one-cycle pulse.
- sData  out  W  snapshot count; must be held stable from sEN until the next sEN.
- sPending  out  1  accumulator nonzero.
- sOverflow  out  1  sticky, accumulator saturated.

Behaviour:
- Reset is asynchronous on sRST_N low. State=IDLE; acc=0; sData=0; sEN=0; sOverflow=0; sPending=0.
- Accumulate, every cycle:
  - If sInc, next acc = acc + sIncAmt, computed in W+1 bits.
  - If the sum exceeds 2^W-1, acc saturates to 2^W-1 and sOverflow is set.
- Trigger condition: acc >= THRESH, or (sFlush and acc != 0).
- FSM states:
  - IDLE: if trigger and sRDY, go to SEND. Else stay.
  - SEND (one cycle):
    - sEN=1; sData <= acc (the pre-increment value).
    - acc <= (sInc ? sIncAmt : 0), so an increment in the launch cycle is never lost or double-counted.
    - Next state is WAIT.
  - WAIT:
    - sEN=0.
    - sRDY is expected low here because the handshake toggle has flipped; accumulation continues.
    - When sRDY=1, go to IDLE.
    - A send from IDLE is possible no earlier than the cycle after.
- sEN is asserted only from SEND. It is never asserted while sRDY=0, and never on two consecutive cycles.
- Minimum spacing between sEN pulses is 3 sCLK, plus the handshake round trip.
- sData changes only on SEND entry. It is stable throughout WAIT, which covers the destination capture window.
- sFlush with acc=0 does nothing. sFlush held high is equivalent to THRESH=1.
- sClrOvf clears sOverflow.
  - If saturation occurs in the same cycle, set wins.
  - Saturation stays latched in acc until the next snapshot.
- sPending = (acc != 0), combinational from the acc register.
- Reset mid-transfer: all state returns to reset values immediately. The pending count is discarded. The handshake stage shares sRST_N, so both sides re-initialise consistently.
- Latency: trigger true in IDLE with sRDY=1 gives sEN high on the next cycle.

Decomposition:
- Shared package holds:
  - the state enum (IDLE=2'd0, SEND=2'd1, WAIT=2'd2), with 2'd3 illegal and decoded to IDLE;
  - the saturating-add width rule as a constant function.
- One natural sub-module: sync_sat_accum, the W-bit saturating accumulator with load-on-snapshot and overflow flag.
- The top level instantiates it with the FSM and the sData register.
- Bench instantiates this block feeding the existing handshake synchronizer, with an unrelated dCLK.

Test Plan:
- Single event: reset, sInc=1 sIncAmt=3 for one cycle, sRDY=1 → next cycle state SEND; sEN=1 one cycle; sData=3; acc=0; dPulse observed downstream; sRDY low then high again.
- Burst during WAIT: after launch, five sInc of 2 while sRDY=0 → no sEN. When sRDY returns, one sEN with sData=10.
- Launch-cycle collision: acc=4, sInc amt 5 in the SEND cycle → sData=4, acc=5 afterwards. Total delivered over two transfers = 9.
- Saturation (W=8): sixty sIncs of 15 before sRDY returns → acc=255, sOverflow=1, next sData=255. sClrOvf clears the flag. sClrOvf with a simultaneous overflow keeps it set.
- THRESH=8 with flush: accumulate 5 → no sEN. Assert sFlush → sEN, sData=5. sFlush with acc=0 → no sEN.
- Reset mid-WAIT: assert sRST_N low while in WAIT with acc=7 → sEN=0, sData=0, acc=0, sOverflow=0 immediately. After release, the first event transfers normally.
